// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg: state encoding and pattern constants for the 111011011011 detector
package seq_detect_pkg;
  localparam int SEQ_LEN = 12;
  localparam logic [SEQ_LEN-1:0] SEQ_PATTERN = 12'b1110_1101_1011;
  typedef enum logic [3:0] {
    S0, S1, S2, S3, S4, S5, S6, S7, S8, S9, S10, S11, S12
  } state_t;
endpackage

// File: rtl/seq_detect_111011011011.sv
// seq_detect_111011011011: Moore detector pulsing det_o for each (overlapping) 1110_1101_1011
module seq_detect_111011011011
  import seq_detect_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic x_i,
  output logic det_o
);
  state_t state, nxt;
  // next state: Sk tracks the longest received suffix matching a pattern prefix
  always_comb begin
    nxt = S0;
    case (state)
      S0:      nxt = x_i ? S1  : S0;
      S1:      nxt = x_i ? S2  : S0;
      S2:      nxt = x_i ? S3  : S0;
      S3:      nxt = x_i ? S3  : S4;
      S4:      nxt = x_i ? S5  : S0;
      S5:      nxt = x_i ? S6  : S0;
      S6:      nxt = x_i ? S3  : S7;
      S7:      nxt = x_i ? S8  : S0;
      S8:      nxt = x_i ? S9  : S0;
      S9:      nxt = x_i ? S3  : S10;
      S10:     nxt = x_i ? S11 : S0;
      S11:     nxt = x_i ? S12 : S0;
      S12:     nxt = x_i ? S3  : S0;
      default: nxt = S0;
    endcase
  end
  // state register; reset wins over the incoming bit
  always_ff @(posedge clk) begin
    state <= reset ? S0 : nxt;
  end
  assign det_o = (state == S12);
endmodule

// File: tb/tb_seq_detect_111011011011.sv
// tb_seq_detect_111011011011: scoreboard bench against a shift-register reference
module tb_seq_detect_111011011011;
  import seq_detect_pkg::*;
  logic clk, reset, x_i, det_o;
  logic [SEQ_LEN-1:0] sh;
  logic q[$];
  int vectors, errors, pulses;
  seq_detect_111011011011 dut (.clk(clk), .reset(reset), .x_i(x_i), .det_o(det_o));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic step(input logic b, input logic r);
    logic e;
    x_i = b;
    reset = r;
    sh = r ? '0 : {sh[SEQ_LEN-2:0], b};
    q.push_back(!r && sh == SEQ_PATTERN);
    @(posedge clk);
    #1;
    e = q.pop_front();
    vectors++;
    assert (det_o === e) else begin
      errors++;
      $error("FAIL det vec=%0d observed=%b expected=%b", vectors, det_o, e);
    end
    if (det_o === 1'b1) pulses++;
  endtask
  task automatic send(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) step(v[i], 1'b0);
  endtask
  task automatic flush();
    for (int i = 0; i < SEQ_LEN; i++) step(1'b0, 1'b0);
    pulses = 0;
  endtask
  task automatic check_pulses(input int exp, input string tag);
    vectors++;
    assert (pulses === exp) else begin
      errors++;
      $error("FAIL %s pulses observed=%0d expected=%0d", tag, pulses, exp);
    end
  endtask
  task automatic check_s0(input string tag);
    vectors++;
    assert (dut.state === S0) else begin
      errors++;
      $error("FAIL %s state observed=%0d expected=%0d", tag, dut.state, S0);
    end
  endtask
  initial begin
    vectors = 0;
    errors = 0;
    pulses = 0;
    sh = '0;
    x_i = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    check_s0("reset");
    pulses = 0;
    send(32'b1110110110111011011011, 22);
    check_pulses(2, "overlap");
    flush();
    send(32'b1111_1110_1101_1011, 16);
    check_pulses(1, "saturate");
    flush();
    send(32'b1110_1101_1010, 12);
    check_pulses(0, "near_miss");
    send(32'b1110_1101_1011, 12);
    check_pulses(1, "after_miss");
    flush();
    send(32'b1110_1101_1, 9);
    step(1'b0, 1'b1);
    check_s0("mid_reset");
    send(32'b011, 3);
    check_pulses(0, "reset_discard");
    send(32'b1110_1101_1011, 12);
    check_pulses(1, "post_reset");
    flush();
    for (int i = 0; i < 200; i++) step(1'($urandom_range(0, 1)), 1'b0);
    for (int i = 0; i < 40; i++) step(1'($urandom_range(0, 3) != 0), 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
